// File: rtl/wide_add_sequencer_if.sv
// Handshake and adder-stage bus for wide_add_sequencer: operand intake, byte-wise
// adder traffic and the result channel. The slave modport is the sequencer side.
interface wide_add_sequencer_if #(
  parameter int NUM_BYTES = 4
);
  localparam int W = 8 * NUM_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;

  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_y;
  logic         add_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport slave (
    input  in_valid, a_in, b_in, cin_in, add_y, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a_in, b_in, cin_in, add_y, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Feeds a NUM_BYTES-wide addition through an external 8-bit adder one byte per
// cycle (LSB first), collects the sum bytes and presents sum/cout/ovf.
module wide_add_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_add_sequencer_if.slave   bus
);
  localparam int W    = 8 * NUM_BYTES;
  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_out_valid;
  logic            r_in_ready;
  logic [7:0]      r_add_a;
  logic [7:0]      r_add_b;
  logic            r_add_cin;

  logic            w_last;
  logic [IDXW:0]   w_next_idx;
  logic [7:0]      w_next_a;
  logic [7:0]      w_next_b;
  logic            w_ovf;

  // Mux-based byte pick keeps an index one past the last byte harmless.
  function automatic logic [7:0] byte_of(input logic [W-1:0] vec, input logic [IDXW:0] k);
    logic [7:0] result;
    result = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (k == (IDXW+1)'(i)) begin
        result = vec[8*i +: 8];
      end
    end
    return result;
  endfunction

  assign w_last     = (r_idx == LAST_IDX);
  assign w_next_idx = {1'b0, r_idx} + {{IDXW{1'b0}}, 1'b1};
  assign w_next_a   = byte_of(r_a, w_next_idx);
  assign w_next_b   = byte_of(r_b, w_next_idx);
  // On the last RUN edge add_y carries the final MSB byte of the sum.
  assign w_ovf      = (r_a[W-1] == r_b[W-1]) && (bus.add_y[7] != r_a[W-1]);

  // Sequencer FSM; the adder-side bytes are prepared one edge ahead so every
  // output comes straight from a register, and r_add_cin doubles as the carry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_add_a     <= 8'h00;
      r_add_b     <= 8'h00;
      r_add_cin   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a_in;
            r_b        <= bus.b_in;
            r_idx      <= '0;
            r_add_a    <= bus.a_in[7:0];
            r_add_b    <= bus.b_in[7:0];
            r_add_cin  <= bus.cin_in;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        ST_RUN: begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_sum[8*i +: 8] <= bus.add_y;
            end
          end
          if (w_last) begin
            r_cout      <= bus.add_cout;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_add_a     <= 8'h00;
            r_add_b     <= 8'h00;
            r_add_cin   <= bus.add_cout;
            r_state     <= ST_DONE;
          end else begin
            r_idx       <= r_idx + IDXW'(1);
            r_add_a     <= w_next_a;
            r_add_b     <= w_next_b;
            r_add_cin   <= bus.add_cout;
          end
        end

        ST_DONE: begin
          r_add_cin <= 1'b0;
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_add_a     <= 8'h00;
          r_add_b     <= 8'h00;
          r_add_cin   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_cin   = (r_state == ST_RUN) ? r_add_cin : 1'b0;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized self-checking bench for wide_add_sequencer (4-byte and 1-byte builds)
// against an arithmetic reference model; the tb also plays the external 8-bit adder.
module tb_wide_add_sequencer;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  wide_add_sequencer_if #(.NUM_BYTES(4)) if4 ();
  wide_add_sequencer_if #(.NUM_BYTES(1)) if1 ();

  assign {if4.add_cout, if4.add_y} = 9'(if4.add_a) + 9'(if4.add_b) + 9'(if4.add_cin);
  assign {if1.add_cout, if1.add_y} = 9'(if1.add_a) + 9'(if1.add_b) + 9'(if1.add_cin);

  wide_add_sequencer #(.NUM_BYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  wide_add_sequencer #(.NUM_BYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end by 500000");
    $fatal(1);
  end

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic cin);
    return 33'(a) + 33'(b) + 33'(cin);
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic cin);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Carry entering byte k of the chain = carry out of the low k bytes' sum.
  function automatic logic ref_carry_in(input logic [31:0] a, input logic [31:0] b, input logic cin, input int k);
    logic [63:0] m;
    logic [63:0] t;
    if (k == 0) return cin;
    m = (64'd1 << (8*k)) - 64'd1;
    t = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return t[8*k];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic accept4(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int waited;
    waited = 0;
    if4.in_valid = 1'b1;
    if4.a_in     = a;
    if4.b_in     = b;
    if4.cin_in   = cin;
    while (!if4.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_ready", 64'(if4.in_ready), 64'd1);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.a_in     = $urandom;
    if4.b_in     = $urandom;
    if4.cin_in   = 1'($urandom);
  endtask

  task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] s;
    s = ref_sum(a, b, cin);
    for (int k = 0; k < 4; k++) begin
      check("run_add_a", 64'(if4.add_a), 64'(a[8*k +: 8]));
      check("run_add_b", 64'(if4.add_b), 64'(b[8*k +: 8]));
      check("run_add_cin", 64'(if4.add_cin), 64'(ref_carry_in(a, b, cin, k)));
      check("run_out_valid", 64'(if4.out_valid), 64'd0);
      check("run_in_ready", 64'(if4.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("done_out_valid", 64'(if4.out_valid), 64'd1);
    check("done_sum", 64'(if4.sum), 64'(s[31:0]));
    check("done_cout", 64'(if4.cout), 64'(s[32]));
    check("done_ovf", 64'(if4.ovf), 64'(ref_ovf(a, b, cin)));
    check("done_in_ready", 64'(if4.in_ready), 64'd0);
  endtask

  task automatic release4(input logic [31:0] a, input logic [31:0] b, input logic cin, input int stall);
    logic [32:0] s;
    s = ref_sum(a, b, cin);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(if4.out_valid), 64'd1);
      check("hold_sum", 64'(if4.sum), 64'(s[31:0]));
      check("hold_cout", 64'(if4.cout), 64'(s[32]));
      check("hold_ovf", 64'(if4.ovf), 64'(ref_ovf(a, b, cin)));
      check("hold_in_ready", 64'(if4.in_ready), 64'd0);
      check("hold_add_a", 64'(if4.add_a), 64'd0);
    end
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    check("rel_out_valid", 64'(if4.out_valid), 64'd0);
    check("rel_in_ready", 64'(if4.in_ready), 64'd1);
    check("rel_sum_held", 64'(if4.sum), 64'(s[31:0]));
  endtask

  initial begin
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vc [4];
    logic [31:0] a1, b1, a2, b2;
    logic        c1, c2;
    logic [7:0]  a8, b8;
    logic        c8;
    logic [8:0]  s8;
    int          ss;

    va = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    vb = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h11111111};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.a_in = '0; if4.b_in = '0; if4.cin_in = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a_in = '0; if1.b_in = '0; if1.cin_in = 1'b0; if1.out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(if4.in_ready), 64'd0);
    check("rst_out_valid", 64'(if4.out_valid), 64'd0);
    check("rst_sum", 64'(if4.sum), 64'd0);
    check("rst_cout", 64'(if4.cout), 64'd0);
    check("rst_ovf", 64'(if4.ovf), 64'd0);
    check("rst_add_a", 64'(if4.add_a), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(if4.in_ready), 64'd1);
    check("idle_add_cin", 64'(if4.add_cin), 64'd0);

    for (int i = 0; i < 4; i++) begin
      accept4(va[i], vb[i], vc[i]);
      run4(va[i], vb[i], vc[i]);
      release4(va[i], vb[i], vc[i], 0);
    end

    a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
    a2 = $urandom; b2 = $urandom; c2 = 1'($urandom);
    accept4(a1, b1, c1);
    run4(a1, b1, c1);
    if4.in_valid = 1'b1; if4.a_in = a2; if4.b_in = b2; if4.cin_in = c2;
    release4(a1, b1, c1, 6);
    accept4(a2, b2, c2);
    run4(a2, b2, c2);
    release4(a2, b2, c2, 0);

    accept4($urandom, $urandom, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(if4.out_valid), 64'd0);
    check("midrst_sum", 64'(if4.sum), 64'd0);
    check("midrst_in_ready", 64'(if4.in_ready), 64'd0);
    check("midrst_add_a", 64'(if4.add_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", 64'(if4.in_ready), 64'd1);
    accept4(32'h00000005, 32'h00000003, 1'b0);
    run4(32'h00000005, 32'h00000003, 1'b0);
    release4(32'h00000005, 32'h00000003, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
      accept4(a1, b1, c1);
      run4(a1, b1, c1);
      release4(a1, b1, c1, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      s8 = 9'(a8) + 9'(b8) + 9'(c8);
      ss = int'($signed(a8)) + int'($signed(b8)) + int'(c8);
      check("b1_in_ready", 64'(if1.in_ready), 64'd1);
      if1.in_valid = 1'b1; if1.a_in = a8; if1.b_in = b8; if1.cin_in = c8;
      @(posedge clk); #1;
      if1.in_valid = 1'b0; if1.a_in = 8'($urandom); if1.b_in = 8'($urandom);
      check("b1_add_a", 64'(if1.add_a), 64'(a8));
      check("b1_add_b", 64'(if1.add_b), 64'(b8));
      check("b1_add_cin", 64'(if1.add_cin), 64'(c8));
      check("b1_run_out_valid", 64'(if1.out_valid), 64'd0);
      @(posedge clk); #1;
      check("b1_out_valid", 64'(if1.out_valid), 64'd1);
      check("b1_sum", 64'(if1.sum), 64'(s8[7:0]));
      check("b1_cout", 64'(if1.cout), 64'(s8[8]));
      check("b1_ovf", 64'(if1.ovf), 64'((ss > 127) || (ss < -128)));
      if1.out_ready = 1'b1;
      @(posedge clk); #1;
      if1.out_ready = 1'b0;
      check("b1_rel_out_valid", 64'(if1.out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
